// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Parameterised synchronous FIFO with flush, used for fetched instructions
// and for the PCs of requests still in flight to instruction memory.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only accepted when a pop frees the slot on the same edge.
    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && (do_pop || (count_q != DEPTH_C));
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_i && push_i && !pop_i) begin
            assert (count_q != DEPTH_C);
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues imem requests and queues results for decode.
// Optional macro FETCH_PERF_EN adds the fetch_bubbles_o stall counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_bubbles_o
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW:0]   in_use;
    logic          grant;
    logic          resp_keep;
    logic          resp_drop;

    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;
    logic [CW-1:0] inst_count;
    logic          inst_empty;
    logic          inst_full;
    logic [31:0]   flight_pc;
    logic [CW-1:0] flight_count;
    logic          flight_empty;
    logic          flight_full;
    logic          unused_status;

    // Queue slots are reserved at request time, so responses can never overflow the queue.
    assign in_use      = {1'b0, inst_count} + {1'b0, outstanding_q};
    assign imem_req_o  = rst_ni && !redirect_i && (in_use < DEPTH_C);
    assign imem_addr_o = pc_q;

    always_comb begin
        grant         = imem_req_o && imem_gnt_i;
        resp_drop     = imem_rvalid_i && (drop_cnt_q != '0);
        resp_keep     = imem_rvalid_i && (drop_cnt_q == '0);
        pc_d          = pc_q;
        outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid_i);
        drop_cnt_d    = drop_cnt_q;
        if (redirect_i) begin
            pc_d       = {redirect_pc_i[31:2], 2'b00};
            drop_cnt_d = outstanding_q - CW'(imem_rvalid_i);
        end else begin
            if (grant) begin
                pc_d = pc_q + 32'd4;
            end
            if (resp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign push_entry = '{pc: flight_pc, instr: imem_rdata_i};

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (redirect_i),
        .push_i  (resp_keep),
        .data_i  (push_entry),
        .pop_i   (instr_ready_i),
        .data_o  (head_entry),
        .count_o (inst_count),
        .empty_o (inst_empty),
        .full_o  (inst_full)
    );

    // Dropped responses belong to flushed requests, so only kept ones pop a PC.
    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_flight_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (redirect_i),
        .push_i  (grant),
        .data_i  (pc_q),
        .pop_i   (resp_keep),
        .data_o  (flight_pc),
        .count_o (flight_count),
        .empty_o (flight_empty),
        .full_o  (flight_full)
    );

    assign unused_status = inst_full ^ flight_empty ^ flight_full ^ (^flight_count);

    assign instr_valid_o = !inst_empty;
    assign instr_o       = inst_empty ? NOP_INSTR : head_entry.instr;
    assign pc_o          = inst_empty ? 32'h0 : head_entry.pc;

`ifdef FETCH_PERF_EN
    logic [31:0] bubbles_q, bubbles_d;

    always_comb begin
        bubbles_d = bubbles_q;
        if (instr_ready_i && !instr_valid_o && (bubbles_q != 32'hFFFF_FFFF)) begin
            bubbles_d = bubbles_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bubbles_q <= '0;
        end else begin
            bubbles_q <= bubbles_d;
        end
    end

    assign fetch_bubbles_o = bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a 1-cycle in-order memory model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_bubbles_o;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] mem_q [$];

    typedef struct {
        logic        gnt;
        logic        rdy;
        logic        redir;
        logic [31:0] redir_pc;
        logic        rv_en;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [$];

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .instr_ready_i (instr_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
`ifdef FETCH_PERF_EN
        ,
        .fetch_bubbles_o (fetch_bubbles_o)
`endif
    );

    function automatic logic [31:0] instrOf(input logic [31:0] addr);
        return ~addr;
    endfunction

    task automatic addVec(input logic gnt, input logic rdy, input logic redir,
                          input logic [31:0] rpc, input logic rv_en, input logic e_req,
                          input logic [31:0] e_addr, input logic e_valid, input logic [31:0] e_pc);
        vec_t v;
        v.gnt = gnt; v.rdy = rdy; v.redir = redir; v.redir_pc = rpc; v.rv_en = rv_en;
        v.exp_req = e_req; v.exp_addr = e_addr; v.exp_valid = e_valid; v.exp_pc = e_pc;
        vecs.push_back(v);
    endtask

    task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory answers the oldest granted address one cycle or more after its grant.
    task automatic applyStimulus(input logic gnt, input logic rdy, input logic redir,
                                 input logic [31:0] rpc, input logic rv_en);
        imem_gnt_i    = gnt;
        instr_ready_i = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        if (rv_en && (mem_q.size() > 0)) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = instrOf(mem_q[0]);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'hDEAD_BEEF;
        end
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic e_req, input logic [31:0] e_addr,
                               input logic e_valid, input logic [31:0] e_pc);
        compareVal($sformatf("%s.req", tag), {31'b0, imem_req_o}, {31'b0, e_req});
        compareVal($sformatf("%s.addr", tag), imem_addr_o, e_addr);
        compareVal($sformatf("%s.valid", tag), {31'b0, instr_valid_o}, {31'b0, e_valid});
        compareVal($sformatf("%s.pc", tag), pc_o, e_valid ? e_pc : 32'h0);
        compareVal($sformatf("%s.instr", tag), instr_o, e_valid ? instrOf(e_pc) : NOP_INSTR);
    endtask

    task automatic clockEdge();
        logic        granted;
        logic [31:0] gaddr;
        logic        resp;
        granted = imem_req_o && imem_gnt_i;
        gaddr   = imem_addr_o;
        resp    = imem_rvalid_i;
        @(posedge clk);
        if (!rst_ni) begin
            mem_q.delete();
        end else begin
            if (resp) void'(mem_q.pop_front());
            if (granted) mem_q.push_back(gaddr);
        end
        #1;
    endtask

    task automatic runVec(input int i);
        applyStimulus(vecs[i].gnt, vecs[i].rdy, vecs[i].redir, vecs[i].redir_pc, vecs[i].rv_en);
        checkOutput($sformatf("row%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                    vecs[i].exp_valid, vecs[i].exp_pc);
        clockEdge();
    endtask

    initial begin
        rst_ni        = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;

        // Startup streaming from RESET_PC
        addVec(1, 1, 0, 0, 1,  1, 32'h100, 0, 0);
        addVec(1, 1, 0, 0, 1,  1, 32'h104, 0, 0);
        addVec(1, 1, 0, 0, 1,  1, 32'h108, 1, 32'h100);
        addVec(1, 1, 0, 0, 1,  1, 32'h10C, 1, 32'h104);
        // Decode stalls for 10 cycles; queue fills and requests stop at 4 in use
        addVec(1, 0, 0, 0, 1,  1, 32'h110, 1, 32'h108);
        addVec(1, 0, 0, 0, 1,  1, 32'h114, 1, 32'h108);
        addVec(1, 0, 0, 0, 1,  0, 32'h118, 1, 32'h108);
        for (int k = 0; k < 7; k++) addVec(1, 0, 0, 0, 1,  0, 32'h118, 1, 32'h108);
        addVec(1, 1, 0, 0, 1,  0, 32'h118, 1, 32'h108);
        // Grant withheld for 3 cycles while the queue drains in order
        addVec(0, 1, 0, 0, 1,  1, 32'h118, 1, 32'h10C);
        addVec(0, 1, 0, 0, 1,  1, 32'h118, 1, 32'h110);
        addVec(0, 1, 0, 0, 1,  1, 32'h118, 1, 32'h114);
        addVec(1, 1, 0, 0, 1,  1, 32'h118, 0, 0);
        addVec(1, 1, 0, 0, 1,  1, 32'h11C, 0, 0);
        addVec(1, 1, 0, 0, 1,  1, 32'h120, 1, 32'h118);
        addVec(1, 1, 0, 0, 1,  1, 32'h124, 1, 32'h11C);
        // Hold a response back to build 2 outstanding, then redirect with rvalid on the edge
        addVec(1, 1, 0, 0, 0,  1, 32'h128, 1, 32'h120);
        addVec(1, 1, 1, 32'h2002, 1,  0, 32'h12C, 0, 0);
        addVec(1, 1, 0, 0, 1,  1, 32'h2000, 0, 0);
        addVec(1, 1, 0, 0, 1,  1, 32'h2004, 0, 0);
        addVec(1, 1, 0, 0, 1,  1, 32'h2008, 1, 32'h2000);
        // Back-to-back redirects, last one wins
        addVec(1, 1, 1, 32'h3000, 1,  0, 32'h200C, 1, 32'h2004);
        addVec(1, 1, 1, 32'h4007, 1,  0, 32'h3000, 0, 0);
        addVec(1, 1, 0, 0, 1,  1, 32'h4004, 0, 0);
        addVec(1, 1, 0, 0, 1,  1, 32'h4008, 0, 0);
        addVec(1, 1, 0, 0, 1,  1, 32'h400C, 1, 32'h4004);
        // PC wraps from the top of the address space
        addVec(1, 1, 1, 32'hFFFF_FFFB, 1,  0, 32'h4010, 1, 32'h4008);
        addVec(1, 1, 0, 0, 1,  1, 32'hFFFF_FFF8, 0, 0);
        addVec(1, 1, 0, 0, 1,  1, 32'hFFFF_FFFC, 0, 0);
        addVec(1, 1, 0, 0, 1,  1, 32'h0000_0000, 1, 32'hFFFF_FFF8);
        addVec(1, 1, 0, 0, 1,  1, 32'h0000_0004, 1, 32'hFFFF_FFFC);
        addVec(1, 1, 0, 0, 1,  1, 32'h0000_0008, 1, 32'h0000_0000);
        // Fill the queue before a mid-stream reset
        addVec(1, 0, 0, 0, 1,  1, 32'h0000_000C, 1, 32'h0000_0004);
        addVec(1, 0, 0, 0, 1,  1, 32'h0000_0010, 1, 32'h0000_0004);
        addVec(1, 0, 0, 0, 1,  0, 32'h0000_0014, 1, 32'h0000_0004);
        addVec(1, 0, 0, 0, 1,  0, 32'h0000_0014, 1, 32'h0000_0004);

        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1, 1, 0, 0, 1);
        checkOutput("reset", 0, RST_PC, 0, 0);

        rst_ni = 1'b1;
        for (int i = 0; i < vecs.size(); i++) runVec(i);

        // Reset with a full queue and active inputs
        rst_ni = 1'b0;
        applyStimulus(1, 1, 0, 0, 1);
        clockEdge();
        applyStimulus(1, 1, 0, 0, 1);
        checkOutput("midreset", 0, RST_PC, 0, 0);
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) runVec(i);

`ifdef FETCH_PERF_EN
        rst_ni = 1'b0;
        applyStimulus(0, 1, 0, 0, 1);
        clockEdge();
        compareVal("bubbles.reset", fetch_bubbles_o, 32'd0);
        rst_ni = 1'b1;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 1, 0, 0, 1);
            clockEdge();
        end
        compareVal("bubbles.five", fetch_bubbles_o, 32'd5);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 0, 1);
            clockEdge();
        end
        compareVal("bubbles.stalled", fetch_bubbles_o, 32'd5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage at the front of the 5-stage pipeline. It owns the architectural PC and issues word fetches to instruction memory over a req/gnt/rvalid handshake. It buffers returned instructions with their PCs in a small in-order queue and presents them to the F->D pipeline register with a valid/ready handshake. Redirects from execute (branches/jumps) flush the queue and discard in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
FIFO_DEPTH, 4, instruction queue entries; power of two, >= 2; also the maximum number of outstanding memory requests

Ports:
clk_i  input  1  clock; all state updates on posedge
rst_ni  input  1  synchronous active-low reset
imem_req_o  output  1  fetch request valid
imem_addr_o  output  32  fetch word address
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  response data valid; responses return in order, at least 1 cycle after gnt
imem_rdata_i  input  32  instruction word
instr_valid_o  output  1  queue head valid toward decode
instr_o  output  32  head instruction
pc_o  output  32  head PC
instr_ready_i  input  1  decode accepts head; 0 = stall
redirect_i  input  1  flush and redirect
redirect_pc_i  input  32  new PC; bits [1:0] forced to 0

Behaviour:
- Reset: a posedge with rst_ni=0 applies pc_q=RESET_PC, queue empty, outstanding=0, drop_cnt=0. Resulting outputs: imem_req_o=0, instr_valid_o=0, instr_o=32'h0000_0013 (NOP), pc_o=0. Reset overrides all other inputs, including mid-transaction. Memory responses to pre-reset requests are the memory's responsibility.
- imem_req_o: asserted when (queue count + outstanding) < FIFO_DEPTH and redirect_i=0. It is combinational from registered state and redirect_i. imem_addr_o=pc_q.
- Grant: on req & gnt, pc_q += 4 (32-bit wrap, 0xFFFF_FFFC -> 0), outstanding++, and the request address is pushed into an in-flight PC queue. The requester holds req/addr stable until gnt.
- Response: on rvalid, outstanding-- and the in-flight PC is popped.
  - If drop_cnt>0: drop_cnt--, data discarded.
  - Else: {pc, rdata} is pushed to the instruction queue.
  - Space is pre-reserved, so a push never hits a full queue. An overflow is an assertion failure.
- Decode side: instr_valid_o = queue not empty. instr_o/pc_o show the head. When empty: NOP and 0. Pop on instr_valid_o & instr_ready_i. Head is stable while stalled.
- Simultaneous push and pop on the same edge is legal; count is unchanged.
- Redirect (priority below reset, above everything else), on an edge with redirect_i=1:
  - pc_q = {redirect_pc_i[31:2],2'b00}.
  - Instruction queue and in-flight PC queue cleared.
  - drop_cnt = outstanding minus 1 if rvalid is high that cycle, else outstanding. A response arriving on the redirect edge is discarded.
  - Pop is ignored.
  - No request is issued in the redirect cycle.
- Latency, with single-cycle memory: redirect at edge N, then imem_req_o at N+1, rvalid at N+2, instr_valid_o at N+3. Back-to-back redirects are legal; only the last takes effect.
- Throughput: 1 instr/cycle sustained with FIFO_DEPTH=4, gnt always 1, 1-cycle response, ready=1.

Optional Feature:
FETCH_PERF_EN. When defined, adds port fetch_bubbles_o (output, 32 bits). It counts cycles with instr_ready_i=1 and instr_valid_o=0, saturating at 32'hFFFF_FFFF, and resets to 0. When undefined, the port and counter are absent and there is no other behavioural difference.

Decomposition:
- fetch_pkg holds:
  - NOP_INSTR=32'h0000_0013
  - DEFAULT_RESET_PC
  - fetch_entry_t struct {logic [31:0] pc; logic [31:0] instr;}
- One sub-module, fetch_fifo: a parameterised synchronous FIFO (WIDTH, DEPTH) with push/pop/flush, count, empty/full, and sync active-low reset. It is instantiated twice: for fetch_entry_t, and for 32-bit in-flight PCs.

Test Plan:
- Reset with RESET_PC=0x100, gnt=1, 1-cycle memory, ready=1 -> addresses 0x100, 0x104, 0x108..., instr_valid_o first high 3 cycles after reset release, then every cycle; pc_o matches each instr_o.
- Hold ready=0 for 10 cycles while streaming -> at most 4 instructions buffered, imem_req_o low once count+outstanding=4, head unchanged. Release -> in-order drain, no loss or duplication.
- gnt low for 3 cycles -> imem_req_o/imem_addr_o stable, pc_q not advanced.
- redirect_i to 0x2002 with 2 outstanding and rvalid on the same edge -> queue empty, the following 1 response dropped, next request addr 0x2000, first delivered pc_o=0x2000.
- Reset asserted mid-stream with a full queue -> next cycle all outputs at reset values, fetch restarts at RESET_PC.
- With FETCH_PERF_EN: 5 empty cycles with ready=1 -> fetch_bubbles_o=5; cycles with ready=0 are not counted.
